// File: rtl/slave_spi.sv
// Mode-0 SPI slave, oversampled on the system clock. Receives MSB-first WIDTH-bit
// words as one-cycle strobes; transmit words arrive through a one-deep holding register.
module slave_spi #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  output logic             miso,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             frame_active
);

  // Fewer than two stages would not be a synchronizer, so clamp.
  localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [SS-1:0]    r_sclk_sync;
  logic [SS-1:0]    r_cs_sync;
  logic [SS-1:0]    r_mosi_sync;
  logic             r_sclk_dly;
  logic             r_cs_dly;

  logic [0:0]       r_state;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_reload_pending;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] r_rx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_tx_underrun;

  logic             r_hold_full;
  logic [WIDTH-1:0] r_hold_data;

  logic w_sclk_s;
  logic w_cs_s;
  logic w_mosi_s;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_cs_rise;
  logic w_cs_fall;
  logic w_active_run;
  logic w_load;
  logic w_accept;
  logic w_last_bit;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sclk_dly  <= 1'b0;
      r_cs_dly    <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SS-2:0], sclk};
      r_cs_sync   <= {r_cs_sync[SS-2:0], cs_n};
      r_mosi_sync <= {r_mosi_sync[SS-2:0], mosi};
      r_sclk_dly  <= r_sclk_sync[SS-1];
      r_cs_dly    <= r_cs_sync[SS-1];
    end
  end

  assign w_sclk_s    = r_sclk_sync[SS-1];
  assign w_cs_s      = r_cs_sync[SS-1];
  assign w_mosi_s    = r_mosi_sync[SS-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_dly;
  assign w_sclk_fall = ~w_sclk_s & r_sclk_dly;
  assign w_cs_rise   = w_cs_s & ~r_cs_dly;
  assign w_cs_fall   = ~w_cs_s & r_cs_dly;

  // A CS release beats any SCLK edge seen in the same cycle.
  assign w_active_run = (r_state == ST_ACTIVE) && !w_cs_rise;
  assign w_load       = ((r_state == ST_IDLE) && w_cs_fall) ||
                        (w_active_run && w_sclk_fall && r_reload_pending);
  assign w_accept     = tx_valid && tx_ready;
  assign w_last_bit   = (r_bit_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_data <= tx_data;
    end else if (w_load) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_bit_cnt        <= '0;
      r_reload_pending <= 1'b0;
      r_tx_shift       <= '0;
      r_rx_shift       <= '0;
      r_rx_data        <= '0;
      r_rx_valid       <= 1'b0;
      r_tx_underrun    <= 1'b0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_tx_underrun <= 1'b0;

      // An empty holding register at load time sends zeros and flags it.
      if (w_load) begin
        r_tx_shift    <= r_hold_full ? r_hold_data : '0;
        r_tx_underrun <= ~r_hold_full;
      end

      if (r_state == ST_IDLE) begin
        if (w_cs_fall) begin
          r_state   <= ST_ACTIVE;
          r_bit_cnt <= '0;
        end
      end else if (w_cs_rise) begin
        r_state          <= ST_IDLE;
        r_bit_cnt        <= '0;
        r_reload_pending <= 1'b0;
      end else begin
        if (w_sclk_rise) begin
          r_rx_shift <= {r_rx_shift[WIDTH-2:0], w_mosi_s};
          if (w_last_bit) begin
            r_rx_data        <= {r_rx_shift[WIDTH-2:0], w_mosi_s};
            r_rx_valid       <= 1'b1;
            r_bit_cnt        <= '0;
            r_reload_pending <= 1'b1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        if (w_sclk_fall) begin
          if (r_reload_pending) begin
            r_reload_pending <= 1'b0;
          end else begin
            r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
          end
        end
      end
    end
  end

  assign frame_active = (r_state == ST_ACTIVE);
  assign miso         = frame_active & r_tx_shift[WIDTH-1];
  assign tx_ready     = ~r_hold_full & ~reset;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign tx_underrun  = r_tx_underrun;

endmodule

// File: tb/tb_slave_spi.sv
// Bench for slave_spi: a behavioural SPI master drives frames while a scoreboard
// holds the expected received and transmitted words.
module tb_slave_spi;

  localparam int H = 6;

  logic       clock = 1'b0;
  logic       reset;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       frame_active;

  int total = 0;
  int bad   = 0;
  int under_cnt = 0;
  int acc_cnt   = 0;
  logic prev_rx_valid = 1'b0;

  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  slave_spi #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clock(clock), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
    .frame_active(frame_active)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Output monitor: rx words are checked against the scoreboard as they appear.
  always @(negedge clock) begin
    if (!reset) begin
      if (rx_valid) begin
        chk("rx_valid_one_cycle", {31'd0, prev_rx_valid}, 32'd0);
        if (exp_rx.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
        else chk("rx_data", {24'd0, rx_data}, {24'd0, exp_rx.pop_front()});
      end
      if (tx_underrun) under_cnt <= under_cnt + 1;
      if (tx_valid && tx_ready) acc_cnt <= acc_cnt + 1;
    end
    prev_rx_valid <= rx_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_tx(input logic [7:0] d);
    int n;
    n = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && n < 1000) begin
      @(negedge clock);
      n++;
    end
    chk("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
    @(negedge clock);
    tx_valid = 1'b0;
    $display("tx push 0x%02h", d);
  endtask

  // Bits are taken from mo[15] downward; the last fall and CS release coincide.
  task automatic spi_frame(input int nbits, input logic [15:0] mo, input bit keep_cs,
                           output logic [15:0] mi);
    mi   = '0;
    cs_n = 1'b0;
    wait_clk(H);
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[15-i];
      wait_clk(H);
      mi[15-i] = miso;
      sclk = 1'b1;
      wait_clk(H);
      sclk = 1'b0;
      if (i == nbits - 1 && !keep_cs) cs_n = 1'b1;
    end
    wait_clk(2 * H);
  endtask

  task automatic full_frame(input int nw, input logic [15:0] mo, input logic [15:0] em,
                            input string tag);
    logic [15:0] mi;
    for (int w = 0; w < nw; w++) begin
      exp_rx.push_back(mo[15-8*w -: 8]);
      exp_tx.push_back(em[15-8*w -: 8]);
    end
    spi_frame(8 * nw, mo, 1'b0, mi);
    for (int w = 0; w < nw; w++)
      chk({tag, "_miso"}, {24'd0, mi[15-8*w -: 8]}, {24'd0, exp_tx.pop_front()});
    chk({tag, "_rx_missing"}, exp_rx.size(), 0);
    $display("frame %s: mosi=0x%04h miso=0x%04h words=%0d", tag, mo, mi, nw);
  endtask

  initial begin
    int u0;
    int a0;
    logic [15:0] dummy;
    reset = 1'b1; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    wait_clk(3);
    chk("rst_miso", {31'd0, miso}, 0);
    chk("rst_rx_data", {24'd0, rx_data}, 0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 0);
    chk("rst_underrun", {31'd0, tx_underrun}, 0);
    chk("rst_frame_active", {31'd0, frame_active}, 0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 0);
    reset = 1'b0;
    wait_clk(1);
    chk("post_rst_tx_ready", {31'd0, tx_ready}, 1);

    // Single word with a preloaded transmit word.
    u0 = under_cnt;
    push_tx(8'hA5);
    chk("t1_full", {31'd0, tx_ready}, 0);
    full_frame(1, 16'h3C00, 16'hA500, "t1");
    chk("t1_underrun", under_cnt - u0, 0);
    chk("t1_tx_ready", {31'd0, tx_ready}, 1);

    // Two back-to-back words, the second transmit word supplied mid-frame.
    u0 = under_cnt;
    push_tx(8'h81);
    fork
      full_frame(2, 16'h1234, 16'h817E, "t2");
      begin
        wait_clk(25);
        chk("t2_frame_active", {31'd0, frame_active}, 1);
        push_tx(8'h7E);
      end
    join
    chk("t2_underrun", under_cnt - u0, 0);

    // Nothing loaded: zeros out, one underrun at CS fall.
    u0 = under_cnt;
    full_frame(1, 16'hFF00, 16'h0000, "t3");
    chk("t3_underrun", under_cnt - u0, 1);

    // Aborted frame after 5 bits, then a full frame.
    u0 = under_cnt;
    spi_frame(5, 16'hA800, 1'b0, dummy);
    chk("t4_frame_active", {31'd0, frame_active}, 0);
    full_frame(1, 16'h5A00, 16'h0000, "t4");
    chk("t4_underrun", under_cnt - u0, 2);

    // Reset in the middle of a frame.
    spi_frame(3, 16'hE000, 1'b1, dummy);
    reset = 1'b1;
    wait_clk(2);
    chk("t5_rst_miso", {31'd0, miso}, 0);
    chk("t5_rst_rx_data", {24'd0, rx_data}, 0);
    chk("t5_rst_frame_active", {31'd0, frame_active}, 0);
    chk("t5_rst_tx_ready", {31'd0, tx_ready}, 0);
    cs_n = 1'b1;
    sclk = 1'b0;
    wait_clk(2);
    reset = 1'b0;
    wait_clk(4);
    u0 = under_cnt;
    push_tx(8'h0F);
    full_frame(1, 16'hF000, 16'h0F00, "t5");
    chk("t5_underrun", under_cnt - u0, 0);

    // Full holding register must not be overwritten by a stalled tx_valid.
    u0 = under_cnt;
    push_tx(8'h55);
    a0 = acc_cnt;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    wait_clk(3);
    chk("t6_stall_ready", {31'd0, tx_ready}, 0);
    full_frame(1, 16'h9900, 16'h5500, "t6a");
    chk("t6_accepts", acc_cnt - a0, 1);
    tx_valid = 1'b0;
    chk("t6_held", {31'd0, tx_ready}, 0);
    full_frame(1, 16'h6600, 16'hC300, "t6b");
    chk("t6_underrun", under_cnt - u0, 0);

    wait_clk(10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
